// File: rtl/iomem_arbiter.sv
// Round-robin two-master arbiter for the MiniSoc iomem slave port, with a
// bus-timeout watchdog that aborts unacknowledged transfers and pulses an irq.
module iomem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                timeout_irq
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt1_s;
  logic            cur_valid_s;
  logic            abort_s;
  logic            rdy_s;
  logic [DATA_W-1:0] rd_s;

  // Next-state, watchdog and the combinational request/response mux.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    s_valid     = 1'b0;
    s_wstrb     = '0;
    s_addr      = '0;
    s_wdata     = '0;
    timeout_irq = 1'b0;
    rdy_s       = 1'b0;
    rd_s        = '0;
    gnt1_s      = (state_q == GRANT1);
    cur_valid_s = gnt1_s ? m1_valid : m0_valid;
    abort_s     = (TIMEOUT != 0) && (cnt_q == TO_C);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (m0_valid) begin
          state_d = GRANT0;
        end else if (m1_valid) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        s_wstrb = gnt1_s ? m1_wstrb : m0_wstrb;
        s_addr  = gnt1_s ? m1_addr  : m0_addr;
        s_wdata = gnt1_s ? m1_wdata : m0_wdata;
        if (abort_s) begin
          // Abort overrides both the slave response and the master's valid.
          rdy_s       = 1'b1;
          rd_s        = {DATA_W{1'b1}};
          timeout_irq = 1'b1;
          last_d      = gnt1_s;
          state_d     = IDLE;
        end else if (!cur_valid_s) begin
          state_d = IDLE;
        end else if (s_ready) begin
          s_valid = 1'b1;
          rdy_s   = 1'b1;
          rd_s    = s_rdata;
          last_d  = gnt1_s;
          state_d = IDLE;
        end else begin
          s_valid = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    m0_ready = rdy_s && !gnt1_s;
    m0_rdata = gnt1_s ? '0 : rd_s;
    m1_ready = rdy_s && gnt1_s;
    m1_rdata = gnt1_s ? rd_s : '0;
  end

  // State, round-robin pointer and watchdog counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed, table-driven bench for iomem_arbiter (TIMEOUT=8); one vector per cycle.
module tb_iomem_arbiter;

  localparam logic [31:0] A0  = 32'h0300_0000;
  localparam logic [31:0] A1  = 32'h0300_0004;
  localparam logic [31:0] W0  = 32'hCAFE_0000;
  localparam logic [31:0] W1  = 32'h1234_5678;
  localparam logic [3:0]  S0  = 4'b0000;
  localparam logic [3:0]  S1  = 4'b0011;
  localparam logic [31:0] RD  = 32'hDEAD_BEEF;
  localparam logic [31:0] ONE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        s_valid, s_ready, timeout_irq;
  logic [31:0] s_addr, s_wdata, s_rdata;

  always #5 clk = ~clk;

  iomem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .timeout_irq(timeout_irq)
  );

  typedef logic [135:0] obs_t;

  typedef struct {
    string       nm;
    logic        rst, m0v, m1v, srdy;
    logic [31:0] srd;
    logic        esv;
    logic [1:0]  esel;   // 0: slave fields zero, 1: m0 fields, 2: m1 fields
    logic        er0;
    logic [31:0] erd0;
    logic        er1;
    logic [31:0] erd1;
    logic        eirq;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string nm, logic rst, logic m0v, logic m1v, logic srdy,
                              logic [31:0] srd, logic esv, logic [1:0] esel, logic er0,
                              logic [31:0] erd0, logic er1, logic [31:0] erd1, logic eirq);
    vec_t v;
    v.nm = nm; v.rst = rst; v.m0v = m0v; v.m1v = m1v; v.srdy = srdy; v.srd = srd;
    v.esv = esv; v.esel = esel; v.er0 = er0; v.erd0 = erd0; v.er1 = er1; v.erd1 = erd1;
    v.eirq = eirq;
    return v;
  endfunction

  function automatic obs_t observe();
    return {s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata, m1_ready, m1_rdata, timeout_irq};
  endfunction

  task automatic cmp(input string nm, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    obs_t        e;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    resetn   = v.rst;
    m0_valid = v.m0v;
    m1_valid = v.m1v;
    s_ready  = v.srdy;
    s_rdata  = v.srd;
    ea = (v.esel == 2'd1) ? A0 : (v.esel == 2'd2) ? A1 : 32'h0;
    ed = (v.esel == 2'd1) ? W0 : (v.esel == 2'd2) ? W1 : 32'h0;
    es = (v.esel == 2'd1) ? S0 : (v.esel == 2'd2) ? S1 : 4'h0;
    e  = {v.esv, ea, ed, es, v.er0, v.erd0, v.er1, v.erd1, v.eirq};
    @(negedge clk);
    cmp(v.nm, observe(), e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sv_cnt, irq_cnt;
    logic got_rdy;
    logic [31:0] rd_at_rdy;

    m0_addr = A0; m0_wdata = W0; m0_wstrb = S0;
    m1_addr = A1; m1_wdata = W1; m1_wstrb = S1;
    resetn = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b0; s_rdata = 32'h0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("reset_hold", 1'b0, 1'b1, 1'b1, 1'b1, RD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_idle_a", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_g0_a",   1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b1, 2'd1, 1'b1, RD, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_idle_b", 1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_g1_a",   1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0));
    vecs.push_back(mk("rr_idle_c", 1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_g0_b",   1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b1, 2'd1, 1'b1, RD, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_idle_d", 1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rr_g1_b",   1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 32'h55, 1'b0));
    vecs.push_back(mk("rd_idle",   1'b1, 1'b1, 1'b0, 1'b1, RD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rd_g0",     1'b1, 1'b1, 1'b0, 1'b1, RD, 1'b1, 2'd1, 1'b1, RD, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rd_done",   1'b1, 1'b0, 1'b0, 1'b1, RD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("wr_idle",   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("wr_wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("wr_ack",    1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAA, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 32'hAAAA, 1'b0));
    vecs.push_back(mk("wr_done",   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("to_idle",   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("to_wait", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("to_abort",  1'b1, 1'b1, 1'b0, 1'b1, RD, 1'b0, 2'd1, 1'b1, ONE, 1'b0, 32'h0, 1'b1));
    vecs.push_back(mk("to_m1_idle",1'b1, 1'b0, 1'b1, 1'b1, 32'h600DF00D, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("to_m1_g1",  1'b1, 1'b0, 1'b1, 1'b1, 32'h600DF00D, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 32'h600DF00D, 1'b0));
    vecs.push_back(mk("pv_idle",   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("pv_drop",   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("pv_after",  1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("mr_idle",   1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("mr_g1",     1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("mr_rst",    1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("mr_after",  1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("mr_g0",     1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b1, 2'd1, 1'b1, RD, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("end_idle",  1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));

    foreach (vecs[i]) apply(vecs[i]);

    // Free-running timeout: count s_valid cycles and irq pulses until m0_ready, bounded.
    m0_valid = 1'b1; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = RD;
    sv_cnt = 0; irq_cnt = 0; got_rdy = 1'b0; rd_at_rdy = 32'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_valid) sv_cnt++;
      if (timeout_irq) irq_cnt++;
      if (m0_ready) begin
        got_rdy = 1'b1;
        rd_at_rdy = m0_rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    cmp("seq_to_ready_seen", obs_t'(got_rdy), obs_t'(1'b1));
    cmp("seq_to_sv_cycles", obs_t'(sv_cnt), obs_t'(8));
    cmp("seq_to_irq_pulses", obs_t'(irq_cnt), obs_t'(1));
    cmp("seq_to_rdata", obs_t'(rd_at_rdy), obs_t'(ONE));
    @(posedge clk);
    #1;
    m0_valid = 1'b0;
    @(negedge clk);
    cmp("seq_to_irq_cleared", obs_t'({timeout_irq, s_valid, m0_ready}), obs_t'(3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
